// File: rtl/life_seq.sv
// life_seq: generation sequencer for the Life cell array.
//
// Runs the free-running cell-scan counter. Turns key-bus edges into step, run/pause and
// clear commands, and schedules whole-frame GEN and CLR passes. Every pass starts on a
// frame boundary.
//
// Ports:
//   clk       clock
//   reset     asynchronous reset, active-high
//   keys      current key code (level); 0 means no key
//   cnt       cell scan address, +1 every cycle, wraps (shared with display refresh)
//   gen_en    high for every cycle of a GEN frame
//   clr_en    high for every cycle of a CLR frame
//   running   run mode active
//   busy      gen_en | clr_en
//   gen_done  one-cycle pulse at cnt==0 after each GEN frame
//   gen_cnt   generations completed since last clear
module life_seq #(
  parameter int unsigned LOG2X    = 3,
  parameter int unsigned LOG2Y    = 3,
  parameter logic [2:0]  KEY_STEP = 3'd1,
  parameter logic [2:0]  KEY_RUN  = 3'd2,
  parameter logic [2:0]  KEY_CLR  = 3'd3,
  parameter int unsigned RATE     = 4,
  parameter int unsigned GW       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             keys,
  output logic [LOG2X+LOG2Y-1:0] cnt,
  output logic                   gen_en,
  output logic                   clr_en,
  output logic                   running,
  output logic                   busy,
  output logic                   gen_done,
  output logic [GW-1:0]          gen_cnt
);

  localparam int unsigned CW = LOG2X + LOG2Y;
  localparam int unsigned DW = (RATE > 1) ? $clog2(RATE) : 1;
  localparam logic [DW-1:0] DivLast = DW'(RATE - 1);

  typedef enum logic [1:0] {StIdle, StGen, StClr} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      kprev_q;
  logic            step_pend_q, step_pend_d;
  logic            clr_pend_q, clr_pend_d;
  logic            running_q, running_d;
  logic [DW-1:0]   div_q, div_d;
  logic [GW-1:0]   gen_cnt_q, gen_cnt_d;
  logic            gen_done_q, gen_done_d;

  logic frame_last;
  logic press_step, press_run, press_clr;

  assign frame_last = &cnt_q;
  assign press_step = (keys == KEY_STEP) && (kprev_q != KEY_STEP);
  assign press_run  = (keys == KEY_RUN)  && (kprev_q != KEY_RUN);
  assign press_clr  = (keys == KEY_CLR)  && (kprev_q != KEY_CLR);

  always_comb begin
    state_d     = state_q;
    step_pend_d = step_pend_q;
    clr_pend_d  = clr_pend_q;
    running_d   = running_q;
    div_d       = div_q;
    gen_cnt_d   = gen_cnt_q;
    gen_done_d  = 1'b0;

    if (frame_last) begin
      case (state_q)
        StIdle: begin
          if (clr_pend_q) begin
            state_d    = StClr;
            clr_pend_d = 1'b0;
          end else if (step_pend_q) begin
            state_d     = StGen;
            step_pend_d = 1'b0;
          end else if (running_q) begin
            if (div_q == DivLast) begin
              state_d = StGen;
              div_d   = '0;
            end else begin
              div_d = div_q + 1'b1;
            end
          end
        end
        StGen: begin
          state_d    = StIdle;
          gen_cnt_d  = gen_cnt_q + 1'b1;
          gen_done_d = 1'b1;
        end
        StClr: begin
          state_d   = StIdle;
          gen_cnt_d = '0;
          div_d     = '0;
        end
        default: state_d = StIdle;
      endcase
    end

    // Presses are applied after the frame decision so a press landing on frame_last
    // is latched for the next frame instead of being consumed or lost.
    if (press_step && !running_q) begin
      step_pend_d = 1'b1;
    end
    if (press_run) begin
      running_d = ~running_q;
      div_d     = '0;
    end
    if (press_clr) begin
      clr_pend_d = 1'b1;
      running_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      kprev_q     <= '0;
      step_pend_q <= 1'b0;
      clr_pend_q  <= 1'b0;
      running_q   <= 1'b0;
      div_q       <= '0;
      gen_cnt_q   <= '0;
      gen_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_q + 1'b1;
      kprev_q     <= keys;
      step_pend_q <= step_pend_d;
      clr_pend_q  <= clr_pend_d;
      running_q   <= running_d;
      div_q       <= div_d;
      gen_cnt_q   <= gen_cnt_d;
      gen_done_q  <= gen_done_d;
    end
  end

  assign cnt      = cnt_q;
  assign gen_en   = (state_q == StGen);
  assign clr_en   = (state_q == StClr);
  assign busy     = gen_en | clr_en;
  assign running  = running_q;
  assign gen_done = gen_done_q;
  assign gen_cnt  = gen_cnt_q;

endmodule

// File: tb/tb_life_seq.sv
// Bench for life_seq with LOG2X=LOG2Y=3 (64-cycle frames) and RATE=4.
// Stimulus pushes expected frame events {kind, frame index, gen_cnt}. A monitor pops
// them when it sees a GEN/CLR frame start or a gen_done pulse. The monitor also
// tracks cnt and the busy/enable invariants every cycle.
module tb_life_seq;

  localparam logic [2:0] KS = 3'd1;
  localparam logic [2:0] KR = 3'd2;
  localparam logic [2:0] KC = 3'd3;
  localparam int EvGen  = 0;
  localparam int EvClr  = 1;
  localparam int EvDone = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  keys = 3'd0;
  logic [5:0]  cnt;
  logic        gen_en, clr_en, running, busy, gen_done;
  logic [15:0] gen_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int kind;
    int frame;
    int gc;
  } ev_t;
  ev_t exp_q[$];

  life_seq #(
    .LOG2X(3), .LOG2Y(3), .KEY_STEP(KS), .KEY_RUN(KR), .KEY_CLR(KC), .RATE(4), .GW(16)
  ) dut (
    .clk(clk), .reset(reset), .keys(keys), .cnt(cnt), .gen_en(gen_en), .clr_en(clr_en),
    .running(running), .busy(busy), .gen_done(gen_done), .gen_cnt(gen_cnt)
  );

  always #5 clk = ~clk;

  // Posedges since reset release; at each negedge cnt should equal cyc mod 64.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cyc=%0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int kind, input int frame, input int gc);
    ev_t e;
    e.kind = kind;
    e.frame = frame;
    e.gc = gc;
    exp_q.push_back(e);
  endtask

  task automatic sb(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected actual kind=%0d frame=%0d gen_cnt=%0d required none",
               kind, cyc / 64, gen_cnt);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.frame != cyc / 64 || e.gc != int'(gen_cnt)) begin
        errors++;
        $display("FAIL sb_event actual kind=%0d frame=%0d gen_cnt=%0d required kind=%0d frame=%0d gen_cnt=%0d",
                 kind, cyc / 64, gen_cnt, e.kind, e.frame, e.gc);
      end
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] k, input int at, input int hold);
    wait_until(at);
    keys = k;
    wait_until(at + hold);
    keys = 3'd0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cnt"}, int'(cnt), 0);
    chk({tag, "_gen_en"}, int'(gen_en), 0);
    chk({tag, "_clr_en"}, int'(clr_en), 0);
    chk({tag, "_running"}, int'(running), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_gen_done"}, int'(gen_done), 0);
    chk({tag, "_gen_cnt"}, int'(gen_cnt), 0);
  endtask

  // Monitor
  initial begin
    logic busy_prev;
    int   run_len;
    busy_prev = 1'b0;
    run_len = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_prev = 1'b0;
        run_len = 0;
      end else begin
        chk("cnt_track", int'(cnt), cyc % 64);
        chk("busy_or", int'(busy), int'(gen_en | clr_en));
        chk("en_excl", int'(gen_en & clr_en), 0);
        if (busy && !busy_prev) sb(gen_en ? EvGen : EvClr);
        if (gen_done) sb(EvDone);
        if (busy) begin
          run_len++;
        end else if (busy_prev) begin
          chk("frame_len", run_len, 64);
          run_len = 0;
        end
        busy_prev = busy;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d required completion", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    // Idle: no events queued, so any GEN/CLR/done would be flagged as unexpected.
    wait_until(500);
    chk("idle_running", int'(running), 0);
    chk("idle_gen_cnt", int'(gen_cnt), 0);

    // Single step at cnt=10 of frame 8, held 200 cycles.
    push(EvGen, 9, 0);
    push(EvDone, 10, 1);
    press(KS, 522, 200);

    // Run mode from frame 12: GEN at frames 16, 21, 26, 31 (5-frame period).
    for (int i = 0; i < 4; i++) begin
      push(EvGen, 16 + 5 * i, 1 + i);
      push(EvDone, 17 + 5 * i, 2 + i);
    end
    press(KR, 778, 12);
    chk("run_on", int'(running), 1);
    press(KR, 2122, 8);
    chk("run_off", int'(running), 0);

    // Step then clear inside frame 40 with gen_cnt=5: CLR first, then GEN.
    wait_until(2560);
    chk("pre_clr_gen_cnt", int'(gen_cnt), 5);
    push(EvClr, 41, 5);
    push(EvGen, 43, 0);
    push(EvDone, 44, 1);
    press(KS, 2565, 5);
    press(KC, 2580, 10);
    wait_until(42 * 64 + 1);
    chk("after_clr_gen_cnt", int'(gen_cnt), 0);

    // Clear while running, during a GEN frame.
    push(EvGen, 49, 1);
    push(EvDone, 50, 2);
    push(EvClr, 51, 2);
    press(KR, 2890, 10);
    wait_until(3160);
    chk("run_in_gen", int'(running), 1);
    chk("gen_active", int'(gen_en), 1);
    press(KC, 3166, 4);
    chk("clr_stops_run", int'(running), 0);
    wait_until(58 * 64);
    chk("post_clr_gen_cnt", int'(gen_cnt), 0);
    chk("post_clr_running", int'(running), 0);

    // Reset at cnt=30 of a GEN frame.
    push(EvGen, 59, 0);
    press(KS, 3722, 8);
    wait_until(3806);
    chk("gen_before_rst", int'(gen_en), 1);
    reset = 1'b1;
    #1;
    check_zero("midrst");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_until(200);
    chk("end_gen_cnt", int'(gen_cnt), 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
